// File: rtl/router_pkg.sv
// Shared router types (flit/VC-state enums, flit struct) and the mesh XY route_compute function.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package router_pkg;

   typedef enum logic [1:0] {
      BODY      = 2'd0,
      HEAD      = 2'd1,
      TAIL      = 2'd2,
      HEAD_TAIL = 2'd3
   } flit_type_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VA = 2'd1,
      ACTIVE  = 2'd2
   } vc_state_e;

   typedef struct packed {
      logic [`FLIT_DATA_WIDTH-1:0] data;
      flit_type_e                  ftype;
   } flit_t;

   localparam int PORT_EAST  = 0;
   localparam int PORT_WEST  = 1;
   localparam int PORT_NORTH = 2;
   localparam int PORT_SOUTH = 3;

   function automatic logic is_head(input flit_type_e t);
      return (t == HEAD) || (t == HEAD_TAIL);
   endfunction

   function automatic logic is_tail(input flit_type_e t);
      return (t == TAIL) || (t == HEAD_TAIL);
   endfunction

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   function automatic int route_compute(input int cur_id, input int dst_id,
                                        input int per_row, input int local_port);
      int cur_x, cur_y, dst_x, dst_y, port;
      cur_x = cur_id % per_row;
      cur_y = cur_id / per_row;
      dst_x = dst_id % per_row;
      dst_y = dst_id / per_row;
      if (dst_x > cur_x)      port = PORT_EAST;
      else if (dst_x < cur_x) port = PORT_WEST;
      else if (dst_y > cur_y) port = PORT_SOUTH;
      else if (dst_y < cur_y) port = PORT_NORTH;
      else                    port = local_port;
      return port;
   endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO, DEPTH a power of two; front flit readable combinationally, write visible next cycle.
module vc_fifo
   import router_pkg::*;
#(
   parameter  int DEPTH    = 4,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  flit_t             din,
   output flit_t             dout,
   output logic              full,
   output logic              empty,
   output logic [PTR_BITS:0] count
);

   flit_t               r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wr_ptr;
   logic [PTR_BITS-1:0] r_rd_ptr;
   logic [PTR_BITS:0]   r_count;

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == (PTR_BITS+1)'(DEPTH));
   assign empty = (r_count == '0);

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC FIFOs + route/VA/SA state machines; one registered flit and one credit per cycle.
// INPUT_UNIT_ERR_CHECK_EN builds the sticky err flag and discard of stray non-head flits; writes to a full VC are never stored.
module vc_input_unit
   import router_pkg::*;
#(
   parameter  int NUM_PORTS      = 5,
   parameter  int NUM_VC         = 4,
   parameter  int VC_DEPTH       = 4,
   parameter  int NUM_ROUTERS    = 16,
   parameter  int ROUTER_PER_ROW = 4,
   parameter  int ROUTER_ID      = 0,
   localparam int VC_BITS        = $clog2(NUM_VC),
   localparam int PTR_BITS       = $clog2(VC_DEPTH),
   localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
   localparam int DW             = `FLIT_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [VC_BITS-1:0]           in_vc,
   input  logic [1:0]                   in_type,
   input  logic [DW-1:0]                in_data,
   output logic [NUM_VC-1:0]            va_req,
   output logic [NUM_VC*NUM_PORTS-1:0]  vc_dst_port,
   input  logic [NUM_VC-1:0]            va_grant,
   input  logic [NUM_VC*VC_BITS-1:0]    va_out_vc,
   output logic [NUM_VC-1:0]            sa_req,
   input  logic [NUM_VC-1:0]            sa_grant,
   output logic                         out_valid,
   output logic [DW-1:0]                out_data,
   output logic [1:0]                   out_type,
   output logic [VC_BITS-1:0]           out_vc,
   output logic                         credit_valid,
   output logic [VC_BITS-1:0]           credit_vc,
   output logic                         err
);

   flit_t                             w_wr_flit;
   flit_t                             w_front [NUM_VC];
   logic [PTR_BITS:0]                 w_count [NUM_VC];
   logic [NUM_VC-1:0]                 w_full;
   logic [NUM_VC-1:0]                 w_empty;
   logic [NUM_VC-1:0]                 w_push;
   logic [NUM_VC-1:0]                 w_sa_req;
   logic [NUM_VC-1:0]                 w_sa_pop;
   logic [NUM_VC-1:0]                 w_drop_pop;
   logic [NUM_VC-1:0]                 w_pop;
   logic [VC_BITS-1:0]                w_pop_idx;
   logic [NUM_VC-1:0][NUM_PORTS-1:0]  w_route_oh;
   int                                w_port;

   vc_state_e                         r_state     [NUM_VC];
   vc_state_e                         w_state_nxt [NUM_VC];
   logic [NUM_VC-1:0][NUM_PORTS-1:0]  r_route;
   logic [NUM_VC-1:0][VC_BITS-1:0]    r_ovc;

   logic                              r_out_valid;
   logic [DW-1:0]                     r_out_data;
   logic [1:0]                        r_out_type;
   logic [VC_BITS-1:0]                r_out_vc;
   logic                              r_credit_valid;
   logic [VC_BITS-1:0]                r_credit_vc;

   assign w_wr_flit.data  = in_data;
   assign w_wr_flit.ftype = flit_type_e'(in_type);

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign w_push[v] = in_valid && (in_vc == VC_BITS'(v)) && !w_full[v];

      vc_fifo #(.DEPTH(VC_DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (w_push[v]),
         .pop   (w_pop[v]),
         .din   (w_wr_flit),
         .dout  (w_front[v]),
         .full  (w_full[v]),
         .empty (w_empty[v]),
         .count (w_count[v])
      );
   end

   // Destination router id rides in the MSBs of the head flit.
   always_comb begin
      w_port     = 0;
      w_route_oh = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_port = route_compute(ROUTER_ID, int'(w_front[v].data[DW-1 -: ROUTER_ID_BITS]),
                                ROUTER_PER_ROW, NUM_PORTS-1);
         for (int p = 0; p < NUM_PORTS; p++) begin
            w_route_oh[v][p] = (w_port == p);
         end
      end
   end

   always_comb begin
      va_req   = '0;
      w_sa_req = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         va_req[v]   = (r_state[v] == WAIT_VA);
         w_sa_req[v] = (r_state[v] == ACTIVE) && (w_count[v] != '0);
      end
   end

   assign sa_req = w_sa_req;

   always_comb begin
      w_sa_pop   = sa_grant & w_sa_req;
      w_drop_pop = '0;
`ifdef INPUT_UNIT_ERR_CHECK_EN
      // Stray flits are discarded only on cycles with no switch pop, lowest VC first.
      if (w_sa_pop == '0) begin
         for (int v = NUM_VC-1; v >= 0; v--) begin
            if ((r_state[v] == IDLE) && !w_empty[v] && !is_head(w_front[v].ftype)) begin
               w_drop_pop    = '0;
               w_drop_pop[v] = 1'b1;
            end
         end
      end
`endif
      w_pop     = w_sa_pop | w_drop_pop;
      w_pop_idx = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (w_pop[v]) w_pop_idx = VC_BITS'(v);
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         w_state_nxt[v] = r_state[v];
         case (r_state[v])
            IDLE:    if (!w_empty[v] && is_head(w_front[v].ftype)) w_state_nxt[v] = WAIT_VA;
            WAIT_VA: if (va_grant[v]) w_state_nxt[v] = ACTIVE;
            ACTIVE:  if (w_sa_pop[v] && is_tail(w_front[v].ftype)) w_state_nxt[v] = IDLE;
            default: w_state_nxt[v] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (reset) r_state[v] <= IDLE;
         else       r_state[v] <= w_state_nxt[v];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_route <= '0;
         r_ovc   <= '0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if ((r_state[v] == IDLE) && (w_state_nxt[v] == WAIT_VA))
               r_route[v] <= w_route_oh[v];
            else if ((r_state[v] == ACTIVE) && (w_state_nxt[v] == IDLE))
               r_route[v] <= '0;
            if ((r_state[v] == WAIT_VA) && va_grant[v])
               r_ovc[v] <= va_out_vc[v*VC_BITS +: VC_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_out_type     <= '0;
         r_out_vc       <= '0;
         r_credit_valid <= 1'b0;
         r_credit_vc    <= '0;
      end else begin
         r_out_valid    <= |w_sa_pop;
         r_credit_valid <= |w_pop;
         r_credit_vc    <= w_pop_idx;
         if (|w_sa_pop) begin
            r_out_data <= w_front[w_pop_idx].data;
            r_out_type <= w_front[w_pop_idx].ftype;
            r_out_vc   <= r_ovc[w_pop_idx];
         end
      end
   end

`ifdef INPUT_UNIT_ERR_CHECK_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= r_err | (in_valid && w_full[in_vc]) | (|w_drop_pop);
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign vc_dst_port  = r_route;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_type     = r_out_type;
   assign out_vc       = r_out_vc;
   assign credit_valid = r_credit_valid;
   assign credit_vc    = r_credit_vc;

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit (default parameters); error-check scenarios run when INPUT_UNIT_ERR_CHECK_EN is defined.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module tb_vc_input_unit;

   localparam int DW = `FLIT_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [1:0]    in_vc = '0;
   logic [1:0]    in_type = '0;
   logic [DW-1:0] in_data = '0;
   logic [3:0]    va_req;
   logic [19:0]   vc_dst_port;
   logic [3:0]    va_grant = '0;
   logic [7:0]    va_out_vc = '0;
   logic [3:0]    sa_req;
   logic [3:0]    sa_grant = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_type;
   logic [1:0]    out_vc;
   logic          credit_valid;
   logic [1:0]    credit_vc;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   vc_input_unit dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_vc        (in_vc),
      .in_type      (in_type),
      .in_data      (in_data),
      .va_req       (va_req),
      .vc_dst_port  (vc_dst_port),
      .va_grant     (va_grant),
      .va_out_vc    (va_out_vc),
      .sa_req       (sa_req),
      .sa_grant     (sa_grant),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_type     (out_type),
      .out_vc       (out_vc),
      .credit_valid (credit_valid),
      .credit_vc    (credit_vc),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] hd(input int dst, input int low);
      logic [DW-1:0] d;
      d = DW'(low);
      d[DW-1 -: 4] = 4'(dst);
      return d;
   endfunction

   task automatic send(input int vc, input int typ, input logic [DW-1:0] data);
      in_valid = 1'b1;
      in_vc    = 2'(vc);
      in_type  = 2'(typ);
      in_data  = data;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [DW-1:0] d, input int typ,
                            input int ovc, input int cvc);
      check_val({tag, ".out_valid"}, 64'(out_valid), 1);
      check_val({tag, ".out_data"}, 64'(out_data), 64'(d));
      check_val({tag, ".out_type"}, 64'(out_type), 64'(typ));
      check_val({tag, ".out_vc"}, 64'(out_vc), 64'(ovc));
      check_val({tag, ".credit_valid"}, 64'(credit_valid), 1);
      check_val({tag, ".credit_vc"}, 64'(credit_vc), 64'(cvc));
   endtask

   logic [DW-1:0] exp_d [5];
   int            exp_t [5];
   int            exp_o [5];
   int            exp_c [5];
   logic [3:0]    grants [5];

   initial begin
      repeat (3) step();
      check_val("rst.va_req", 64'(va_req), 0);
      check_val("rst.sa_req", 64'(sa_req), 0);
      check_val("rst.out_valid", 64'(out_valid), 0);
      check_val("rst.credit_valid", 64'(credit_valid), 0);
      check_val("rst.err", 64'(err), 0);
      check_val("rst.out_data", 64'(out_data), 0);
      check_val("rst.out_type", 64'(out_type), 0);
      check_val("rst.out_vc", 64'(out_vc), 0);
      check_val("rst.dst_port", 64'(vc_dst_port), 0);
      reset = 1'b0;

      // Head+tail on VC2 to this router: eject port, downstream VC 1.
      send(2, 3, hd(0, 'hA5));
      check_val("ht.va_req_early", 64'(va_req), 0);
      step();
      check_val("ht.va_req", 64'(va_req), 4'b0100);
      check_val("ht.dst_port", 64'(vc_dst_port), 20'h04000);
      va_grant = 4'b0100; va_out_vc = 8'h10;
      step();
      va_grant = '0;
      check_val("ht.sa_req", 64'(sa_req), 4'b0100);
      check_val("ht.va_req_off", 64'(va_req), 0);
      sa_grant = 4'b0100;
      step();
      sa_grant = '0;
      check_out("ht", hd(0, 'hA5), 3, 1, 2);
      check_val("ht.sa_req_idle", 64'(sa_req), 0);
      check_val("ht.dst_cleared", 64'(vc_dst_port), 0);
      step();
      check_val("ht.out_valid_off", 64'(out_valid), 0);
      check_val("ht.credit_off", 64'(credit_valid), 0);

      // 4-flit packet on VC0 to router 5 (east), sa_grant held past the tail.
      send(0, 1, hd(5, 1));
      send(0, 0, 2);
      send(0, 0, 3);
      send(0, 2, 4);
      check_val("pkt4.va_req", 64'(va_req), 4'b0001);
      check_val("pkt4.dst_port", 64'(vc_dst_port), 20'h00001);
      va_grant = 4'b0001; va_out_vc = 8'h03;
      step();
      va_grant = '0;
      check_val("pkt4.sa_req", 64'(sa_req), 4'b0001);
      sa_grant = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step();
         check_out($sformatf("pkt4.f%0d", i), (i == 0) ? hd(5, 1) : DW'(i + 1),
                   (i == 0) ? 1 : ((i == 3) ? 2 : 0), 3, 0);
      end
      check_val("pkt4.sa_req_idle", 64'(sa_req), 0);
      check_val("pkt4.va_req_idle", 64'(va_req), 0);
      check_val("pkt4.dst_cleared", 64'(vc_dst_port), 0);
      step();
      sa_grant = '0;
      check_val("pkt4.ignored_grant", 64'(out_valid), 0);
      check_val("pkt4.no_credit", 64'(credit_valid), 0);

      // Interleaved packets on VC1 (local, out VC2) and VC3 (east, out VC0).
      send(1, 1, hd(0, 'h11));
      send(3, 1, hd(1, 'h31));
      send(1, 2, 'h12);
      send(3, 0, 'h32);
      send(3, 2, 'h33);
      check_val("il.va_req", 64'(va_req), 4'b1010);
      check_val("il.dst_port", 64'(vc_dst_port), 20'h08200);
      va_grant = 4'b1010; va_out_vc = 8'h08;
      step();
      va_grant = '0;
      check_val("il.sa_req", 64'(sa_req), 4'b1010);
      grants[0] = 4'b0010; exp_d[0] = hd(0, 'h11); exp_t[0] = 1; exp_o[0] = 2; exp_c[0] = 1;
      grants[1] = 4'b1000; exp_d[1] = hd(1, 'h31); exp_t[1] = 1; exp_o[1] = 0; exp_c[1] = 3;
      grants[2] = 4'b0010; exp_d[2] = 'h12;        exp_t[2] = 2; exp_o[2] = 2; exp_c[2] = 1;
      grants[3] = 4'b1000; exp_d[3] = 'h32;        exp_t[3] = 0; exp_o[3] = 0; exp_c[3] = 3;
      grants[4] = 4'b1000; exp_d[4] = 'h33;        exp_t[4] = 2; exp_o[4] = 0; exp_c[4] = 3;
      for (int i = 0; i < 5; i++) begin
         sa_grant = grants[i];
         step();
         check_out($sformatf("il.g%0d", i), exp_d[i], exp_t[i], exp_o[i], exp_c[i]);
      end
      sa_grant = '0;
      check_val("il.sa_req_done", 64'(sa_req), 0);
      step();

      // Reset in the middle of a packet on VC0.
      send(0, 1, hd(0, 'h41));
      send(0, 0, 'h42);
      va_grant = 4'b0001; va_out_vc = 8'h00;
      step();
      va_grant = '0;
      check_val("rmid.sa_req_pre", 64'(sa_req), 4'b0001);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("rmid.sa_req", 64'(sa_req), 0);
      check_val("rmid.va_req", 64'(va_req), 0);
      check_val("rmid.out_valid", 64'(out_valid), 0);
      check_val("rmid.credit", 64'(credit_valid), 0);
      check_val("rmid.dst_port", 64'(vc_dst_port), 0);
      send(0, 3, hd(0, 'h51));
      step();
      check_val("rmid.new_va_req", 64'(va_req), 4'b0001);
      check_val("rmid.new_dst", 64'(vc_dst_port), 20'h00010);
      va_grant = 4'b0001; va_out_vc = 8'h02;
      step();
      va_grant = '0;
      sa_grant = 4'b0001;
      step();
      sa_grant = '0;
      check_out("rmid.new", hd(0, 'h51), 3, 2, 0);
      step();

`ifdef INPUT_UNIT_ERR_CHECK_EN
      // Writes to a full VC0 are dropped, with and without a same-cycle pop.
      reset = 1'b1; step(); reset = 1'b0;
      check_val("full.err_rst", 64'(err), 0);
      send(0, 1, hd(0, 'h61));
      send(0, 0, 'h62);
      send(0, 0, 'h63);
      send(0, 0, 'h64);
      check_val("full.err_pre", 64'(err), 0);
      send(0, 0, 'h65);
      check_val("full.err", 64'(err), 1);
      va_grant = 4'b0001; va_out_vc = 8'h01;
      step();
      va_grant = '0;
      sa_grant = 4'b0001;
      send(0, 0, 'h66);
      check_out("full.f0", hd(0, 'h61), 1, 1, 0);
      for (int i = 1; i < 4; i++) begin
         step();
         check_out($sformatf("full.f%0d", i), DW'('h61 + i), 0, 1, 0);
      end
      check_val("full.count4", 64'(sa_req), 0);
      sa_grant = '0;
      send(0, 2, 'h67);
      check_val("full.tail_req", 64'(sa_req), 4'b0001);
      sa_grant = 4'b0001;
      step();
      sa_grant = '0;
      check_out("full.tail", 'h67, 2, 1, 0);

      // Body flit at the front of an idle VC2.
      reset = 1'b1; step(); reset = 1'b0;
      check_val("stray.err_rst", 64'(err), 0);
      send(2, 0, 'h77);
      check_val("stray.va_req", 64'(va_req), 0);
      check_val("stray.credit_early", 64'(credit_valid), 0);
      step();
      check_val("stray.credit", 64'(credit_valid), 1);
      check_val("stray.credit_vc", 64'(credit_vc), 2);
      check_val("stray.out_valid", 64'(out_valid), 0);
      check_val("stray.err", 64'(err), 1);
      step();
      check_val("stray.credit_once", 64'(credit_valid), 0);
      check_val("stray.va_req_late", 64'(va_req), 0);
      check_val("stray.sa_req", 64'(sa_req), 0);
`else
      check_val("noerr.err", 64'(err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vc_input_unit.md
# vc_input_unit

Parametrised per-port input unit for the virtual-channel router. It replaces single-flit VC slots with VC_DEPTH-deep per-VC FIFOs and carries multi-flit packets (head/body/tail). Each VC runs its own routing/allocation state machine and returns one credit upstream per flit read. One instance sits on each router input port, between the link and the VC/switch allocators.

## Interface
- NUM_PORTS, 5: router ports; the local/eject port is index NUM_PORTS-1.
- NUM_VC, 4: virtual channels per port.
- VC_DEPTH, 4: flits per VC FIFO; must be a power of two and at least 2.
- NUM_ROUTERS, 16: routers in the mesh.
- ROUTER_PER_ROW, 4: mesh row width.
- ROUTER_ID, 0: this router's id.
- Derived: VC_BITS = $clog2(NUM_VC), PTR_BITS = $clog2(VC_DEPTH), ROUTER_ID_BITS = $clog2(NUM_ROUTERS).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  flit present on the link this cycle.
- in_vc  in  VC_BITS  target VC of the incoming flit.
- in_type  in  2  flit type: 0 body, 1 head, 2 tail, 3 head+tail.
- in_data  in  `FLIT_DATA_WIDTH  flit payload; on head flits the destination router id is in the MSBs.
- va_req  out  NUM_VC  per-VC request to the VC allocator.
- vc_dst_port  out  NUM_VC x NUM_PORTS  latched one-hot output port per VC.
- va_grant  in  NUM_VC  VC allocation granted.
- va_out_vc  in  NUM_VC x VC_BITS  downstream VC assigned with the grant.
- sa_req  out  NUM_VC  per-VC switch request.
- sa_grant  in  NUM_VC  one-hot or zero; selects the VC to read this cycle.
- out_valid  out  1  registered flit toward the crossbar.
- out_data  out  `FLIT_DATA_WIDTH  registered flit payload.
- out_type  out  2  registered flit type.
- out_vc  out  VC_BITS  downstream VC of the flit.
- credit_valid  out  1  one credit returned upstream.
- credit_vc  out  VC_BITS  VC the credit belongs to.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- Each VC has a FIFO with separate read and write pointers that wrap at VC_DEPTH, plus a PTR_BITS+1 bit count.
- An incoming flit is written to FIFO[in_vc] on the clock edge. The upstream sender guarantees credit before sending.
- Per-VC state machine, one state register per VC:
  - IDLE: when the FIFO front holds a head flit, compute the route with the existing route_compute, latch the one-hot vc_dst_port, and go to WAIT_VA.
  - WAIT_VA: va_req = 1. On va_grant, latch va_out_vc and go to ACTIVE.
  - ACTIVE: sa_req = (count != 0). On sa_grant, pop the front flit. Popping a tail or head+tail flit returns the VC to IDLE and clears the latched route.
- sa_grant to a VC whose sa_req is 0 is ignored.
- Body or tail flits reaching the front of an IDLE VC are protocol errors.
- A write to a full FIFO is a protocol error, even if the same VC is read in the same cycle.
- Write and read to the same non-full VC in the same cycle are both performed; count is unchanged.
- Reset values: all FIFOs empty, all states IDLE, va_req/sa_req/out_valid/credit_valid/err = 0, out_data/out_type/out_vc = 0.

## Timing
- A written flit is visible at the FIFO front on the next cycle.
- IDLE to WAIT_VA takes 1 cycle, so va_req rises 2 cycles after a head flit is written into an empty VC.
- va_grant in cycle t gives ACTIVE and sa_req in cycle t+1.
- sa_grant in cycle t gives out_valid/out_data/out_vc and credit_valid/credit_vc in cycle t+1.
- At most one pop and one credit per cycle.
- A popped head+tail flit returns its VC to IDLE at t+1. A new head already at the front is routed at t+1.
- Reset asserted mid-packet discards all buffered flits and returns no credits; upstream resets in the same cycle.

## Configuration
- INPUT_UNIT_ERR_CHECK_EN defined:
  - A write to a full FIFO is dropped and sets err.
  - A non-head flit at the front of an IDLE VC is popped, discarded and sets err, with no SA request; its credit is still returned.
  - err clears only on reset.
- Not defined:
  - err is tied to 0 and no checks are built.
  - A full-FIFO write and a non-head flit in IDLE have unspecified results.

## Structure
- Shared package router_pkg holds:
  - the flit_type_e enum (BODY, HEAD, TAIL, HEAD_TAIL);
  - the vc_state_e enum (IDLE, WAIT_VA, ACTIVE);
  - the flit_t struct {data, type}.
- One sub-module, vc_fifo: depth-parametrised FIFO with push, pop, full, empty and count, instantiated NUM_VC times.

## Test plan
- Head+tail flit on VC 2 with destination at this router: va_req[2] rises 2 cycles after the write; va_grant with va_out_vc=1; sa_grant gives out_vc=1 and out_type=3 next cycle, credit_vc=2, and VC 2 back to IDLE.
- 4-flit packet (H,B,B,T) on VC 0 with VC_DEPTH=4 and sa_grant held: 4 consecutive out_valid, 4 credits, state IDLE after the tail.
- Two packets interleaved on VC 1 and VC 3 with alternating sa_grant: each output stream keeps its flit order and credit_vc matches the granted VC.
- Fifth write to full VC 0 with the macro on: flit dropped, err=1, count stays 4. Same write with a simultaneous pop: still dropped.
- Body flit at the front of an IDLE VC with the macro on: err=1, no va_req, one credit returned.
- Reset asserted mid-packet: next cycle all sa_req/va_req=0, out_valid=0, and a new head is routed normally.
